weight_fetch_seq: RTL and testbench

Read sequencer that sits directly upstream of the flash memory controller (fmc). On a start command it walks a block of flash addresses, issues one fmc read per word using a one-cycle ready pulse, and captures the returned word after the fmc's fixed read latency. Captured words are buffered in a small FIFO and streamed to the downstream MAC/weight consumer over a valid/ready handshake.

---
 rtl/weight_fetch_seq.sv | 184 ++++++++++++++++++
 tb/tb_weight_fetch_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_seq.sv
// Read sequencer in front of the flash controller: one read in flight at a time, words buffered
// in a small FIFO for the weight consumer. Optional FETCH_CHECKSUM_EN adds a running word sum.
module weight_fetch_seq #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned READ_LAT   = 13,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_words,
   output logic              busy,
   output logic              done,
   output logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] wt_data,
   output logic              wt_valid,
   input  logic              wt_ready
`ifdef FETCH_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned WCNT_W = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;
   // WAIT spans READ_LAT-1 cycles, counter runs 0 .. READ_LAT-2
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(READ_LAT - 2);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapture, StFinish} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   rem_q, rem_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                mem_ready_q, mem_ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   fifo_q [FIFO_DEPTH];
   logic [DATA_W-1:0]   fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [DATA_W-1:0]   wt_data_q, wt_data_d;
   logic                push, pop;
`ifdef FETCH_CHECKSUM_EN
   logic [DATA_W-1:0]   checksum_q, checksum_d;
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      wcnt_d   = wcnt_q;
      done_d   = 1'b0;
      push     = 1'b0;
      pop      = (count_q != '0) && wt_ready;
`ifdef FETCH_CHECKSUM_EN
      checksum_d = checksum_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (start) begin
`ifdef FETCH_CHECKSUM_EN
               checksum_d = '0;
`endif
               if (num_words != '0) begin
                  addr_d  = base_addr;
                  rem_d   = num_words;
                  state_d = StIssue;
               end else begin
                  state_d = StFinish;
               end
            end
         end
         StIssue: begin
            // mem_ready_q already encodes the FIFO-room decision for this cycle
            if (mem_ready_q) begin
               wcnt_d  = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            wcnt_d = wcnt_q + WCNT_W'(1);
            if (wcnt_q == WAIT_LAST) begin
               state_d = StCapture;
            end
         end
         StCapture: begin
            push   = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - ADDR_W'(1);
`ifdef FETCH_CHECKSUM_EN
            checksum_d = checksum_q + mem_data;
`endif
            state_d = (rem_q == ADDR_W'(1)) ? StFinish : StIssue;
         end
         StFinish: begin
            if (count_q == '0) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         fifo_d[wr_ptr_q] = mem_data;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      // Head word is registered; fifo_d already holds a same-cycle push
      wt_data_d = (count_d != '0) ? fifo_d[rd_ptr_d] : wt_data_q;

      mem_ready_d = (state_d == StIssue) && (count_d < CNT_W'(FIFO_DEPTH));
      busy_d      = (state_d != StIdle) || done_d;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         rem_q       <= '0;
         wcnt_q      <= '0;
         mem_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fifo_q      <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wt_data_q   <= '0;
`ifdef FETCH_CHECKSUM_EN
         checksum_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         wcnt_q      <= wcnt_d;
         mem_ready_q <= mem_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fifo_q      <= fifo_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wt_data_q   <= wt_data_d;
`ifdef FETCH_CHECKSUM_EN
         checksum_q  <= checksum_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_ready = mem_ready_q;
   assign mem_addr  = addr_q;
   assign wt_data   = wt_data_q;
   assign wt_valid  = (count_q != '0);
`ifdef FETCH_CHECKSUM_EN
   assign checksum  = checksum_q;
`endif

   a_ready_pulse: assert property (@(posedge clk) disable iff (!n_rst)
      mem_ready |=> !mem_ready);
   a_capture_room: assert property (@(posedge clk) disable iff (!n_rst)
      (state_q == StCapture) |-> (count_q < CNT_W'(FIFO_DEPTH)));
   a_done_busy: assert property (@(posedge clk) disable iff (!n_rst)
      done |-> busy);

endmodule

// File: tb/tb_weight_fetch_seq.sv
// Bench for weight_fetch_seq: fmc latency model plus an occupancy/event-count reference.
module tb_weight_fetch_seq;

   localparam int LAT   = 13;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0;
   logic [15:0] num_words = '0;
   logic [15:0] mem_data = '0;
   logic        wt_ready = 1'b0;
   logic        busy, done, mem_ready, wt_valid;
   logic [15:0] mem_addr, wt_data;
`ifdef FETCH_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   weight_fetch_seq dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .busy      (busy),
      .done      (done),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .wt_data   (wt_data),
      .wt_valid  (wt_valid),
      .wt_ready  (wt_ready)
`ifdef FETCH_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] salt;
   logic [15:0] forced [3];
   bit          use_forced = 1'b0;

   typedef struct {
      logic [15:0] base;
      logic [15:0] n;
      int          mode;       // 0: always ready, 1: random ready
      int          hold;       // wt_ready held low while cycle < hold
      int          rst_at;     // cycle of mid-run reset, -1 for none
      int          exp_done;   // absolute done cycle, -1 if not fixed
      int          exp_reads;
      int          exp_hold_reads;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] word_of(input int idx, input logic [15:0] addr);
      if (use_forced && idx < 3) return forced[idx];
      return {addr[7:0], addr[15:8]} ^ salt;
   endfunction

   task automatic check_reset_state();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_mem_ready", mem_ready, 1'b0);
      check("rst_mem_addr", mem_addr, 16'h0000);
      check("rst_wt_valid", wt_valid, 1'b0);
      check("rst_wt_data", wt_data, 16'h0000);
`ifdef FETCH_CHECKSUM_EN
      check("rst_checksum", checksum, 16'h0000);
`endif
   endtask

   // Cycle 0 is the start cycle; every later cycle is checked against event counts.
   task automatic run(input logic [15:0] base, input logic [15:0] n, input int mode,
                      input int hold, input int rst_at, output int done_cyc,
                      output int reads, output int reads_at_hold);
      int          issued, pops, last_iss, due, exp_done, pushes, occ, next_ok;
      bit          outstanding, exp_mr, finished;
      logic [15:0] due_word, exp_addr;
      issued = 0; pops = 0; last_iss = -100; due = -1;
      exp_done = (n == 16'd0) ? 2 : -1;
      done_cyc = -1; reads_at_hold = -1; finished = 1'b0;

      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_mem_ready", mem_ready, 1'b0);
      start = 1'b1; base_addr = base; num_words = n;
      wt_ready = (hold > 0) ? 1'b0 : 1'b1;

      for (int t = 1; t < 3000 && !finished; t++) begin
         @(negedge clk);
         start = 1'b0; base_addr = 16'($urandom); num_words = 16'($urandom);
         if (t == hold) reads_at_hold = issued;
         if (t == rst_at) begin
            n_rst = 1'b0;
            #1;
            check_reset_state();
            @(negedge clk);
            n_rst = 1'b1;
            finished = 1'b1;
         end else begin
            outstanding = (issued > 0) && (t <= last_iss + LAT);
            pushes  = outstanding ? issued - 1 : issued;
            occ     = pushes - pops;
            next_ok = (issued == 0) ? 1 : last_iss + LAT + 1;
            exp_mr  = (issued < int'(n)) && !outstanding && (t >= next_ok) && (occ < DEPTH);
            check("mem_ready", mem_ready, exp_mr);
            if (n != 16'd0) begin
               exp_addr = base + 16'(pushes);
               check("mem_addr", mem_addr, exp_addr);
            end
            check("wt_valid", wt_valid, occ > 0);
            if (wt_valid && occ > 0) begin
               exp_addr = base + 16'(pops);
               check("wt_data", wt_data, word_of(pops, exp_addr));
            end
            if (exp_done < 0 || t < exp_done) begin
               check("done_low", done, 1'b0);
               check("busy_high", busy, 1'b1);
            end else if (t == exp_done) begin
               check("done_pulse", done, 1'b1);
               check("busy_in_done", busy, 1'b1);
            end else begin
               check("done_after", done, 1'b0);
               check("busy_after", busy, 1'b0);
               finished = 1'b1;
            end
            if (done && done_cyc < 0) done_cyc = t;
            if (!finished) begin
               // start while waiting on the fmc must be ignored
               if (outstanding && t > last_iss && t <= last_iss + LAT - 1 && ($urandom % 4) == 0)
                  start = 1'b1;
               if (mem_ready) begin
                  issued++;
                  last_iss = t;
                  due      = t + LAT;
                  due_word = word_of(issued - 1, mem_addr);
               end
               if (t < hold) wt_ready = 1'b0;
               else if (mode == 0) wt_ready = 1'b1;
               else wt_ready = 1'($urandom % 2);
               if (wt_valid && wt_ready) begin
                  pops++;
                  if (pops == int'(n)) exp_done = t + 2;
               end
               mem_data = (t == due) ? due_word : 16'($urandom);
            end
         end
      end
      check("run_finished", finished, 1'b1);
      reads = issued;
   endtask

   vec_t tbl [7];

   initial begin
      int          dc, rd, rh;
      logic [15:0] sum;
      tbl[0] = '{16'h0010, 16'd3, 0, 0,   -1, 45, 3, -1};
      tbl[1] = '{16'h1234, 16'd0, 0, 0,   -1, 2,  0, -1};
      tbl[2] = '{16'h0100, 16'd6, 0, 200, -1, -1, 6, 4};
      tbl[3] = '{16'hFFFE, 16'd3, 0, 0,   -1, 45, 3, -1};
      tbl[4] = '{16'h0200, 16'd4, 0, 0,   20, -1, 2, -1};
      tbl[5] = '{16'h4000, 16'd2, 0, 0,   -1, 31, 2, -1};
      tbl[6] = '{16'h0001, 16'd1, 0, 0,   -1, 17, 1, -1};
      forced[0] = 16'h8000; forced[1] = 16'h8001; forced[2] = 16'h0005;
      salt = 16'($urandom);

      repeat (2) @(negedge clk);
      check_reset_state();
      n_rst = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run(tbl[i].base, tbl[i].n, tbl[i].mode, tbl[i].hold, tbl[i].rst_at, dc, rd, rh);
         if (tbl[i].exp_done >= 0) check("done_cycle", dc, tbl[i].exp_done);
         check("read_count", rd, tbl[i].exp_reads);
         if (tbl[i].exp_hold_reads >= 0) check("reads_before_release", rh, tbl[i].exp_hold_reads);
      end

      for (int i = 0; i < 8; i++) begin
         logic [15:0] b, nw;
         int          h;
         b  = (i % 3 == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF)) : 16'($urandom);
         nw = 16'($urandom_range(0, 7));
         h  = ($urandom % 2 == 0) ? 0 : int'($urandom_range(20, 90));
         run(b, nw, 1, h, -1, dc, rd, rh);
         check("rand_read_count", rd, 32'(nw));
`ifdef FETCH_CHECKSUM_EN
         sum = '0;
         for (int k = 0; k < int'(nw); k++) sum = sum + word_of(k, b + 16'(k));
         check("rand_checksum", checksum, sum);
`endif
      end

`ifdef FETCH_CHECKSUM_EN
      use_forced = 1'b1;
      run(16'h0300, 16'd3, 0, 0, -1, dc, rd, rh);
      @(negedge clk);
      check("checksum_wrap", checksum, 16'h0006);
      use_forced = 1'b0;
`endif
      sum = '0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
